uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, is the serial bit rate.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-006 rx_data  output  8  received byte; valid while rx_valid=1.
REQ-007 rx_valid  output  1  byte available; held until accepted.
REQ-008 rx_ready  input  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1 on the same edge.
REQ-009 rx_busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 frame_err  output  1  one-cycle pulse when a frame has a low stop-bit sample.
REQ-011 overrun  output  1  one-cycle pulse when a completed byte is dropped because rx_valid is still pending.

Function
REQ-012 CLKS_PER_BIT SHALL be CLK_FREQ/BAUD (integer division); HALF_BIT SHALL be CLKS_PER_BIT/2.
REQ-013 The block SHALL pass rx through a two-flop synchronizer (rx_s); both flops SHALL reset to 1; all decisions use rx_s only.
REQ-014 The bit-period counter SHALL be 16 bits wide; the bit index SHALL be 3 bits wide.
REQ-015 The FSM SHALL have five states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: counter=0, index=0; rx_s=0 -> START.
REQ-017 START: the counter SHALL count to HALF_BIT-1; at that cycle, rx_s=0 -> DATA with counter=0; rx_s=1 -> IDLE (glitch rejected, no outputs).
REQ-018 DATA: the counter SHALL count to CLKS_PER_BIT-1; at that cycle, rx_s SHALL be stored into shift-register bit [index] and the counter cleared.
REQ-019 DATA: index<7 -> increment; index=7 -> STOP.
REQ-020 STOP: the counter SHALL count to CLKS_PER_BIT-1; at that cycle, rx_s=1 -> deliver the byte (REQ-021) then IDLE; rx_s=0 -> pulse frame_err, discard the byte, go to WAIT_HIGH.
REQ-021 Delivery: if rx_valid=0, or rx_valid=1 with rx_ready=1 on that edge, rx_data SHALL load the shift register and rx_valid SHALL be 1 on the next cycle.
REQ-022 Delivery with rx_valid=1 and rx_ready=0: overrun SHALL pulse; rx_data and rx_valid SHALL be unchanged.
REQ-023 WAIT_HIGH: remain until rx_s=1, then -> IDLE; no new start is detected while the line stays low (break condition).
REQ-024 Handshake without a new delivery: rx_valid&rx_ready SHALL clear rx_valid on the next cycle; rx_data SHALL hold its value.
REQ-025 rx_valid SHALL NOT depend combinationally on rx_ready; all outputs SHALL be registered, except rx_busy, which is decoded from the state.
REQ-026 Latency: rx_valid SHALL rise exactly one cycle after the stop-bit sample edge.
REQ-027 The stop-bit sample edge SHALL occur about 2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the falling edge on rx.
REQ-028 Back-to-back frames: a start bit beginning immediately after the stop bit SHALL be received with no lost byte.

Reset
REQ-029 On rst=1 the block SHALL set: state=IDLE, synchronizer flops=1, counter=0, index=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0.
REQ-030 Reset mid-frame SHALL abandon the partial byte with no pulses; the next full frame after release SHALL be received correctly.

Verification (bench uses CLK_FREQ=1_600_000, BAUD=100_000, so CLKS_PER_BIT=16)
REQ-031 Test: frame 0xA5 with rx_ready=0 -> rx_valid=1, rx_data=8'hA5 one cycle after the stop sample, held until rx_ready=1, then cleared next cycle.
REQ-032 Test: rx low for 3 cycles, then high -> no rx_valid, no frame_err; rx_busy returns to 0 after the half-bit check.
REQ-033 Test: frame 0x3C with stop bit 0, line held low for 40 cycles -> single frame_err pulse, no rx_valid, FSM in WAIT_HIGH until rx returns high.
REQ-034 Test: frames 0x11 then 0x22 with rx_ready=0 -> rx_data=8'h11 retained, one overrun pulse at the 0x22 stop sample.
REQ-035 Test: frames 0x00, 0xFF, 0x5A back-to-back with rx_ready=1 -> three rx_valid pulses carrying 00, FF, 5A in order, no errors.
REQ-036 Test: rst asserted during bit 4 of 0x96, then frame 0x69 -> outputs at reset values after rst, then rx_data=8'h69, no frame_err/overrun.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized line, mid-bit sampling, and a
// held rx_valid/rx_ready output with frame-error and overrun pulses.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
  // are both 1; rx_valid then stays high with rx_data stable until that edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        idx_d = 3'd0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = 16'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = 16'd0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 16'd0;
          if (rx_s_q) begin
            state_d = IDLE;
            // A pending unaccepted byte wins; the new one is dropped.
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; rx is driven on falling
// clock edges and every check goes through check().
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vr_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic drive_bits(input logic [7:0] data);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    drive_bits(data);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  // pulse counters and accepted-byte capture
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && !valid_prev) vr_cnt++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
      end
      valid_prev = rx_valid;
    end
  end

  initial begin
    int fe0, ov0, vr0;
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_state", state_dbg, S_IDLE);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 held while rx_ready=0; valid exactly one cycle after stop sample
    fe0 = fe_cnt; ov0 = ov_cnt;
    drive_bits(8'hA5);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("a5_pre_valid", rx_valid, 0);
    @(negedge clk);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    repeat (30) @(negedge clk);
    check("a5_hold_valid", rx_valid, 1);
    check("a5_hold_data", rx_data, 8'hA5);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("a5_cleared", rx_valid, 0);
    check("a5_data_kept", rx_data, 8'hA5);
    check("a5_no_err", fe_cnt - fe0 + ov_cnt - ov0, 0);
    repeat (5) @(negedge clk);

    // 3-cycle glitch is rejected at the half-bit check
    vr0 = vr_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("gl_busy_early", rx_busy, 1);
    repeat (6) @(negedge clk);
    check("gl_busy_late", rx_busy, 1);
    @(negedge clk);
    check("gl_busy_done", rx_busy, 0);
    repeat (20) @(negedge clk);
    check("gl_no_valid", vr_cnt - vr0, 0);
    check("gl_no_ferr", fe_cnt - fe0, 0);

    // 0x3C with low stop bit, line held low for 40 cycles
    vr0 = vr_cnt; fe0 = fe_cnt;
    drive_bits(8'h3C);
    rx = 1'b0;
    repeat (11) @(negedge clk);
    check("fe_pulse", frame_err, 1);
    check("fe_state", state_dbg, S_WAIT_HIGH);
    @(negedge clk);
    check("fe_pulse_end", frame_err, 0);
    repeat (27) @(negedge clk);
    check("fe_still_wait", state_dbg, S_WAIT_HIGH);
    check("fe_busy", rx_busy, 1);
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("fe_idle", state_dbg, S_IDLE);
    check("fe_one_pulse", fe_cnt - fe0, 1);
    check("fe_no_valid", vr_cnt - vr0, 0);
    check("fe_valid_low", rx_valid, 0);

    // 0x11 then 0x22 unaccepted -> overrun, first byte kept
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    check("ov_pulses", ov_cnt - ov0, 1);
    check("ov_valid", rx_valid, 1);
    check("ov_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    check("ov_drain", rx_valid, 0);

    // back-to-back 00, FF, 5A with rx_ready=1
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h5A);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    check("b2b_count", got_q.size(), 3);
    check("b2b_rises", vr_cnt - vr0, 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) check($sformatf("b2b_byte%0d", i), got_q[i], exp_q[i]);
    check("b2b_no_err", fe_cnt - fe0 + ov_cnt - ov0, 0);

    // reset during bit 4 of 0x96, then 0x69
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h96 >> i));
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mr_valid", rx_valid, 0);
    check("mr_data", rx_data, 8'h00);
    check("mr_busy", rx_busy, 0);
    check("mr_state", state_dbg, S_IDLE);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mr_idle_after", rx_busy, 0);
    send_frame(8'h69, 1'b1);
    repeat (5) @(negedge clk);
    check("mr_count", got_q.size(), 1);
    if (got_q.size() > 0) check("mr_byte", got_q[0], 8'h69);
    check("mr_data_reg", rx_data, 8'h69);
    check("mr_no_err", fe_cnt - fe0 + ov_cnt - ov0, 0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
